// File: rtl/tone_sample_gen.sv
// Note-to-sample generator: square wave at the requested half-period, shaped by an
// attack/sustain/release envelope and written to the audio codec once per sample tick.
module tone_sample_gen #(
    parameter int NOTE_W       = 20,
    parameter int SAMPLE_DIV   = 1042,
    parameter int AMP_PEAK     = 10000000,
    parameter int ATTACK_STEP  = 100000,
    parameter int RELEASE_STEP = 50000
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic [NOTE_W-1:0] note_half_period,
    input  logic              note_on,
    input  logic              audio_out_allowed,
    output logic              write_audio_out,
    output logic [31:0]       left_channel_audio_out,
    output logic [31:0]       right_channel_audio_out,
    output logic              active,
    output logic              overrun
);

    localparam int                DIV_W    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [32:0]       PEAK_X   = 33'(AMP_PEAK);
    localparam logic [32:0]       ATK_X    = 33'(ATTACK_STEP);
    localparam logic [31:0]       REL_V    = 32'(RELEASE_STEP);
    localparam logic [NOTE_W-1:0] PER_ONE  = NOTE_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ATTACK,
        S_SUSTAIN,
        S_RELEASE
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [31:0]         r_env;
    logic [31:0]         w_env_nxt;
    logic [32:0]         w_env_add;
    logic                r_gate;
    logic [NOTE_W-1:0]   r_period;
    logic [NOTE_W-1:0]   r_cnt;
    logic                r_pol;
    logic [DIV_W-1:0]    r_div;
    logic                r_pending;

    logic                w_gate;
    logic                w_gate_rise;
    logic                w_new_period;
    logic                w_latch;
    logic                w_tick;
    logic                w_wr;
    logic [31:0]         w_sample;

    assign w_gate       = note_on && (note_half_period != '0);
    assign w_gate_rise  = w_gate && !r_gate;
    assign w_new_period = w_gate && r_gate && (note_half_period != r_period);
    assign w_latch      = w_gate_rise || w_new_period;

    assign w_tick = (r_div == DIV_LAST);
    assign w_wr   = r_pending && audio_out_allowed;

    assign active                  = (r_state != S_IDLE);
    assign right_channel_audio_out = left_channel_audio_out;

    // Sample tick divider; a tick that finds the previous sample unwritten is dropped.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_div     <= '0;
            r_pending <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            r_div <= w_tick ? '0 : r_div + 1'b1;
            if (w_wr)
                r_pending <= 1'b0;
            else if (w_tick)
                r_pending <= 1'b1;
            if (w_tick && r_pending)
                overrun <= 1'b1;
        end
    end

    // Square-wave phase; restarts from the low half whenever a new period is latched.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_gate   <= 1'b0;
            r_period <= '0;
            r_cnt    <= '0;
            r_pol    <= 1'b0;
        end else begin
            r_gate <= w_gate;
            if (w_latch) begin
                r_period <= note_half_period;
                r_cnt    <= '0;
                r_pol    <= 1'b0;
            end else if (r_period != '0) begin
                if (r_cnt == r_period - PER_ONE) begin
                    r_cnt <= '0;
                    r_pol <= ~r_pol;
                end else begin
                    r_cnt <= r_cnt + PER_ONE;
                end
            end
        end
    end

    // Envelope steps once per written sample, saturating at the peak and at zero.
    always_comb begin
        w_env_nxt = r_env;
        w_env_add = {1'b0, r_env} + ATK_X;
        if (write_audio_out) begin
            if (r_state == S_ATTACK)
                w_env_nxt = (w_env_add >= PEAK_X) ? PEAK_X[31:0] : w_env_add[31:0];
            else if (r_state == S_RELEASE)
                w_env_nxt = (r_env > REL_V) ? (r_env - REL_V) : '0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_gate_rise)
                    w_state_nxt = S_ATTACK;
            end
            S_ATTACK: begin
                if (!w_gate)
                    w_state_nxt = S_RELEASE;
                else if ({1'b0, w_env_nxt} == PEAK_X)
                    w_state_nxt = S_SUSTAIN;
            end
            S_SUSTAIN: begin
                // Gate fall takes priority over a simultaneous period change.
                if (!w_gate)
                    w_state_nxt = S_RELEASE;
                else if (w_new_period)
                    w_state_nxt = S_ATTACK;
            end
            S_RELEASE: begin
                if (w_gate_rise || w_new_period)
                    w_state_nxt = S_ATTACK;
                else if (w_env_nxt == '0)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_env   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_env   <= w_env_nxt;
        end
    end

    always_comb begin
        w_sample = '0;
        if (r_state != S_IDLE)
            w_sample = r_pol ? r_env : (32'd0 - r_env);
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            write_audio_out        <= 1'b0;
            left_channel_audio_out <= '0;
        end else begin
            write_audio_out <= w_wr;
            if (w_wr)
                left_channel_audio_out <= w_sample;
        end
    end

endmodule

// File: doc/tone_sample_gen.md
Name: tone_sample_gen

Overview:
- Sits between the note sequencer (song FSM / line-clear beep logic) and Audio_Controller.
- Converts a note request (half-period in 50 MHz cycles plus a gate) into an enveloped square-wave sample stream.
- Paces samples at a fixed rate and drives the Audio_Controller write handshake (audio_out_allowed / write_audio_out), removing the clicks and the ungated writes of the raw snd toggle.

Parameters:
- NOTE_W, 20, width of note_half_period
- SAMPLE_DIV, 1042, CLOCK_50 cycles per sample tick (~48 kHz)
- AMP_PEAK, 10000000, sustain amplitude (unsigned, < 2^31)
- ATTACK_STEP, 100000, amplitude increment per written sample in ATTACK
- RELEASE_STEP, 50000, amplitude decrement per written sample in RELEASE

Ports:
- CLOCK_50  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-high reset
- note_half_period  in  NOTE_W  half period of requested tone in clock cycles; 0 = rest
- note_on  in  1  gate; high while a note should sound
- audio_out_allowed  in  1  Audio_Controller output FIFO has space
- write_audio_out  out  1  one-cycle write strobe to Audio_Controller
- left_channel_audio_out  out  32  signed sample, valid while write_audio_out is high
- right_channel_audio_out  out  32  identical to left
- active  out  1  high whenever state != IDLE
- overrun  out  1  sticky; set when a sample tick arrives while the previous sample is still pending

Behaviour:
- Reset (asynchronous): all outputs 0, state IDLE, env=0, pol=0, phase cnt=0, latched period=0, tick divider=0, pending=0.
- Gate definition: gate = note_on && (note_half_period != 0).
- Period latch:
  - On a rising edge of gate, or on a change of note_half_period while gate is high, latch note_half_period next cycle, clear cnt, set pol=0.
- Phase counter:
  - cnt increments every cycle while latched period != 0.
  - When cnt == period-1: cnt<=0 and pol toggles. So pol toggles every `period` cycles.
  - The phase counter keeps running in RELEASE using the last latched period.
- Envelope FSM (state register updates 1 cycle after the triggering input):
  - IDLE: gate rise -> ATTACK.
  - ATTACK: gate low -> RELEASE. Otherwise, on each written sample, env = min(env+ATTACK_STEP, AMP_PEAK); when env reaches AMP_PEAK -> SUSTAIN.
  - SUSTAIN: env held at AMP_PEAK; gate low -> RELEASE; new period -> ATTACK (env unchanged, so no click).
  - RELEASE: on each written sample, env = max(env-RELEASE_STEP, 0); env==0 -> IDLE; gate rise or new period -> ATTACK from the current env.
  - env updates only on cycles where write_audio_out=1.
- Sample value: pol ? env : -env (32-bit two's complement). In IDLE the sample is 0.
- Sample pacing:
  - The tick divider counts 0..SAMPLE_DIV-1; tick asserts on wrap; pending is set on tick.
  - Write condition: pending && audio_out_allowed. On the next edge, write_audio_out=1 for exactly one cycle, the sample is registered onto both channels that same edge, and pending clears.
  - Outputs hold their value when write_audio_out=0.
- Write rate: at most one write per tick, never two writes in consecutive cycles. Samples are written continuously, including zeros in IDLE, so the codec stays fed.
- Tick with pending still set: the tick is dropped (no queueing) and overrun is set sticky until reset.
- Simultaneous gate fall and period change: gate fall wins (-> RELEASE).
- Reset mid-note: immediate return to reset values; no release tail.

Test Plan:
- Reset, audio_out_allowed=1, gate low for 5000 cycles -> writes every 1042 cycles, all samples 0, active=0, overrun=0.
- note_half_period=113636, note_on=1 -> ATTACK; after 100 writes env=10000000 and state SUSTAIN; pol toggles exactly every 113636 cycles; samples are +/-10000000.
- Drop note_on after SUSTAIN -> |sample| falls by 50000 per write; after 200 writes sample=0, state IDLE, active=0.
- During SUSTAIN, change period 113636 -> 75843 -> cnt resets; next toggle 75843 cycles later; no sample magnitude discontinuity.
- Hold audio_out_allowed=0 for 3000 cycles -> no writes, overrun=1 and stays 1; on release, exactly one write in the next cycle.
- Assert reset for 1 cycle mid-ATTACK (env=300000) -> outputs and env 0 immediately; writes resume at the next tick with sample 0.
